formula_res_fifo: RTL

Credit-based result buffer directly downstream of the pipelined sqrt-formula stage. That stage has fixed latency and no backpressure, so this block reserves a storage slot at issue time and grants issue permission upstream only while a slot is guaranteed. Results are captured on arrival and drained through a valid/ready output port, which decouples the non-stallable pipe from a stallable consumer.

---
 rtl/formula_res_fifo_pkg.sv | 14 +
 rtl/formula_res_fifo_mem.sv | 25 ++
 rtl/formula_res_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/formula_res_fifo_pkg.sv
// Shared defaults and types for the formula result FIFO.
package formula_res_fifo_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultCntW  = $clog2(DefaultDepth) + 1;
  localparam int unsigned DefaultPtrW  = $clog2(DefaultDepth);

  // Count of entries, 0..DEPTH inclusive.
  typedef logic [DefaultCntW-1:0] cnt_t;
  // Storage index, wraps naturally at DEPTH (power of two).
  typedef logic [DefaultPtrW-1:0] ptr_t;

endpackage

// File: rtl/formula_res_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, no reset.
module formula_res_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/formula_res_fifo.sv
// Credit-based result buffer behind the non-stallable sqrt-formula pipe.
// Optional high-water mark tracking: define FORMULA_RES_FIFO_STATS_EN.
module formula_res_fifo
  import formula_res_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_vld,
  output logic             can_issue,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] level,
  output logic             err_ovf,
  output logic             err_unexp,
  output logic [CNT_W-1:0] hwm
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] stored_q, stored_d;
  logic [CNT_W-1:0] inflight;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unexp_q, err_unexp_d;
  logic             issue, accept, pop;

  assign can_issue = (total_q < CNT_W'(DEPTH));
  assign inflight  = total_q - stored_q;
  assign issue     = issue_vld & can_issue;
  assign accept    = in_vld & (inflight != '0);
  assign out_vld   = (stored_q != '0);
  assign pop       = out_vld & out_rdy;

  always_comb begin
    total_d     = total_q;
    stored_d    = stored_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_ovf_d   = err_ovf_q | (issue_vld & ~can_issue);
    err_unexp_d = err_unexp_q | (in_vld & (inflight == '0));

    if (issue && !pop) begin
      total_d = total_q + CNT_W'(1);
    end else if (!issue && pop) begin
      total_d = total_q - CNT_W'(1);
    end

    if (accept && !pop) begin
      stored_d = stored_q + CNT_W'(1);
    end else if (!accept && pop) begin
      stored_d = stored_q - CNT_W'(1);
    end

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q     <= '0;
      stored_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      total_q     <= total_d;
      stored_q    <= stored_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_ovf_q   <= err_ovf_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  formula_res_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  assign level     = total_q;
  assign err_ovf   = err_ovf_q;
  assign err_unexp = err_unexp_q;

`ifdef FORMULA_RES_FIFO_STATS_EN
  logic [CNT_W-1:0] hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else if (total_q > hwm_q) begin
      hwm_q <= total_q;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule
